// File: rtl/activation_if.sv
// activation_if: handshake bundle between the hard-sigmoid activation stage,
// the upstream inner-product neuron and the downstream layer.
//
// Parameters:
//   W - activation output width
//
// Signals:
//   train                            - selects the backward pass at the result handshake
//   argument_valid/ready/data[15:0]  - signed Q8.8 pre-activation from the neuron
//   result_valid/ready/data[W-1:0]   - unsigned activation to the next layer
//   error_valid/ready/data[15:0]     - signed error from the next layer
//   propagate_valid/ready/data[15:0] - scaled error back into the neuron
//
// Modports:
//   slave  - the activation stage
//   master - the surrounding fabric (neuron + next layer)
interface activation_if #(
  parameter int W = 8
);
  logic                train;
  logic                argument_valid;
  logic                argument_ready;
  logic signed [15:0]  argument_data;
  logic                result_valid;
  logic                result_ready;
  logic [W-1:0]        result_data;
  logic                error_valid;
  logic                error_ready;
  logic signed [15:0]  error_data;
  logic                propagate_valid;
  logic                propagate_ready;
  logic signed [15:0]  propagate_data;

  modport slave (
    input  train,
    input  argument_valid, argument_data,
    output argument_ready,
    output result_valid, result_data,
    input  result_ready,
    input  error_valid, error_data,
    output error_ready,
    output propagate_valid, propagate_data,
    input  propagate_ready
  );

  modport master (
    output train,
    output argument_valid, argument_data,
    input  argument_ready,
    input  result_valid, result_data,
    output result_ready,
    output error_valid, error_data,
    input  error_ready,
    input  propagate_valid, propagate_data,
    output propagate_ready
  );
endinterface

// File: rtl/activation.sv
// activation: hard-sigmoid stage downstream of the inner-product neuron.
//
// Forward pass: y = (argument >>> SLOPE) + 2**(W-1), clamped to [0, 2**W-1].
// Training pass (train=1 at the result handshake): the next layer's error is
// scaled by the derivative (2**-SLOPE in the linear region, 0 when saturated)
// and handed back to the neuron.
//
// Parameters:
//   W     - activation output width (full scale 2**W-1 ~ 1.0)
//   SLOPE - right shift applied to the input (linear gradient 2**-SLOPE)
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset
//   bus   - activation_if.slave handshake bundle (argument, result, error,
//           propagate channels plus train)
//
// Build option:
//   ACTIVATION_LEAKY_EN - when defined, the saturated-region gradient is
//                         error >>> (SLOPE+4) instead of 0.
module activation #(
  parameter int W     = 8,
  parameter int SLOPE = 2
) (
  input  logic          clock,
  input  logic          reset,
  activation_if.slave   bus
);

  localparam int FULL = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  typedef enum logic [1:0] {
    ARG = 2'd0,
    RES = 2'd1,
    DEL = 2'd2,
    PRP = 2'd3
  } state_t;

  state_t              state, state_next;

  logic                result_valid_q, result_valid_d;
  logic [W-1:0]        result_data_q, result_data_d;
  logic                propagate_valid_q, propagate_valid_d;
  logic signed [15:0]  propagate_data_q, propagate_data_d;
  logic                saturated_q, saturated_d;

  // Forward datapath, evaluated every cycle and captured at the argument handshake.
  logic signed [31:0]  arg_ext;
  logic signed [31:0]  arg_shift;
  logic signed [31:0]  y;
  logic                y_low, y_high;
  logic [W-1:0]        y_clamped;

  always_comb begin
    arg_ext   = 32'(bus.argument_data);
    arg_shift = arg_ext >>> SLOPE;
    y         = arg_shift + HALF;
    y_low     = (y < 0);
    y_high    = (y > FULL);
    if (y_low)
      y_clamped = '0;
    else if (y_high)
      y_clamped = W'(FULL);
    else
      y_clamped = y[W-1:0];
  end

  // Backward datapath: derivative-scaled error for each region.
  logic signed [15:0]  err_linear;
  logic signed [15:0]  err_saturated;

  always_comb begin
    err_linear = bus.error_data >>> SLOPE;
`ifdef ACTIVATION_LEAKY_EN
    err_saturated = bus.error_data >>> (SLOPE + 4);
`else
    err_saturated = '0;
`endif
  end

  // Ready is implied by the state in each case arm, so only valid is tested.
  always_comb begin
    state_next        = state;
    result_valid_d    = result_valid_q;
    result_data_d     = result_data_q;
    propagate_valid_d = propagate_valid_q;
    propagate_data_d  = propagate_data_q;
    saturated_d       = saturated_q;

    case (state)
      ARG: begin
        if (bus.argument_valid) begin
          result_data_d  = y_clamped;
          saturated_d    = y_low | y_high;
          result_valid_d = 1'b1;
          state_next     = RES;
        end
      end
      RES: begin
        if (result_valid_q && bus.result_ready) begin
          result_valid_d = 1'b0;
          state_next     = bus.train ? DEL : ARG;
        end
      end
      DEL: begin
        if (bus.error_valid) begin
          propagate_data_d  = saturated_q ? err_saturated : err_linear;
          propagate_valid_d = 1'b1;
          state_next        = PRP;
        end
      end
      PRP: begin
        if (propagate_valid_q && bus.propagate_ready) begin
          propagate_valid_d = 1'b0;
          state_next        = ARG;
        end
      end
      default: begin
        state_next = ARG;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ARG;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_valid_q    <= 1'b0;
      result_data_q     <= '0;
      propagate_valid_q <= 1'b0;
      propagate_data_q  <= '0;
      saturated_q       <= 1'b0;
    end else begin
      result_valid_q    <= result_valid_d;
      result_data_q     <= result_data_d;
      propagate_valid_q <= propagate_valid_d;
      propagate_data_q  <= propagate_data_d;
      saturated_q       <= saturated_d;
    end
  end

  assign bus.argument_ready  = (state == ARG);
  assign bus.error_ready     = (state == DEL);
  assign bus.result_valid    = result_valid_q;
  assign bus.result_data     = result_data_q;
  assign bus.propagate_valid = propagate_valid_q;
  assign bus.propagate_data  = propagate_data_q;

  // Each valid flag tracks exactly one state.
  a_result_valid_state: assert property (
    @(posedge clock) disable iff (reset) result_valid_q == (state == RES));
  a_propagate_valid_state: assert property (
    @(posedge clock) disable iff (reset) propagate_valid_q == (state == PRP));

endmodule
